// File: rtl/cdb_pkg.sv
// Shared CDB definitions: field widths and the result entry layout used by the
// execution-unit result queues, the CDB arbiter and the exu2cdb interface.
package cdb_pkg;

    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 6;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] wdata;
        logic [ID_W-1:0]   inst_id;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_result_queue.sv
// Per-execution-unit result FIFO feeding the fixed-priority CDB arbiter.
// Buffers completed results so a unit losing arbitration keeps running.
module cdb_result_queue
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic [DATA_W-1:0]            in_wdata,
    input  logic [ID_W-1:0]              in_inst_id,
    output logic                         cdb_req,
    input  logic                         cdb_rdy,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [DATA_W-1:0]            cdb_wdata,
    output logic [ID_W-1:0]              cdb_inst_id,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_enq;
    logic               w_deq;
    cdb_entry_t         w_head_entry;
    cdb_entry_t         w_in_entry;
    logic [CNT_W-1:0]   w_count_d;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // in_ready deliberately ignores cdb_rdy: no arbiter-to-unit combinational path.
    assign in_ready = !w_full && !flush;
    assign cdb_req  = !w_empty && !flush;

    assign w_enq = in_valid && in_ready;
    assign w_deq = cdb_req && cdb_rdy;

    assign w_in_entry.tag     = in_tag;
    assign w_in_entry.wdata   = in_wdata;
    assign w_in_entry.inst_id = in_inst_id;

    assign w_head_entry = w_empty ? '0 : r_mem[r_head];
    assign cdb_tag      = w_head_entry.tag;
    assign cdb_wdata    = w_head_entry.wdata;
    assign cdb_inst_id  = w_head_entry.inst_id;

    assign occupancy = r_count;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_enq, w_deq})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= w_count_d;
        end
    end

    // Storage is not reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= w_in_entry;
        end
    end

endmodule
